// File: rtl/sprite_pkg.sv
// Shared sprite constants: ROM geometry, colour key, requester IDs and arbiter state encoding.
// Imported by the arbiter, its interface and the bench.
package sprite_pkg;
  localparam int SPR_ADDR_W = 14;
  localparam int SPR_DATA_W = 12;
  localparam logic [SPR_DATA_W-1:0] SPR_TRANSPARENT = 12'hF0F;

  localparam int REQ_MARIO = 0;
  localparam int REQ_ENEMY = 1;
  localparam int REQ_COIN  = 2;
  localparam int REQ_BLOCK = 3;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } arb_state_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant, ROM-side and tagged-response signals between the sprite engines, the arbiter and the ROM.
// slave = arbiter side, master = engines plus ROM side.
interface sprite_rom_arbiter_if import sprite_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SPR_ADDR_W,
  parameter int DATA_W  = SPR_DATA_W
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rom_en;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      rsp_valid;
  logic [IW-1:0]             rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_opaque;

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_opaque
  );

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rom_en, rom_addr, rsp_valid, rsp_id, rsp_data, rsp_opaque
  );
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of req scanning start, start+1, ... modulo N.
// Purely combinational; any=0 when no bit is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle sprite ROM between sprite engines, bounded burst ownership.
// Grant is combinational; tagged response 2 cycles after grant; fully pipelined, no backpressure.
module sprite_rom_arbiter import sprite_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = SPR_ADDR_W,
  parameter int DATA_W  = SPR_DATA_W,
  parameter int BURST   = 16,
  parameter logic [DATA_W-1:0] TRANSPARENT = SPR_TRANSPARENT
) (
  input logic clk,
  input logic rst,
  sprite_rom_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  arb_state_t         state, state_nxt;
  logic [IW-1:0]      owner, owner_nxt, start, pick_idx, gnt_idx;
  logic [CW-1:0]      burst_cnt, burst_cnt_nxt;
  logic [NUM_REQ-1:0] pick_oh, gnt_oh;
  logic               pick_any, keep, any_gnt;

  logic               pipe_valid;
  logic [IW-1:0]      pipe_id;
  logic               rsp_valid_q, rsp_opaque_q;
  logic [IW-1:0]      rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;

  assign start = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Ownership only persists across consecutive grants; after an idle cycle the scan restarts at owner+1.
  always_comb begin
    keep          = (state == ST_BURST) && bus.req[owner] && (burst_cnt < CW'(BURST - 1));
    gnt_oh        = '0;
    gnt_idx       = owner;
    any_gnt       = 1'b0;
    state_nxt     = state;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    if (!rst) begin
      if (keep) begin
        gnt_oh[owner] = 1'b1;
        any_gnt       = 1'b1;
      end else if (pick_any) begin
        gnt_oh  = pick_oh;
        gnt_idx = pick_idx;
        any_gnt = 1'b1;
      end
    end
    if (!any_gnt) begin
      state_nxt     = ST_IDLE;
      burst_cnt_nxt = '0;
    end else begin
      state_nxt = ST_BURST;
      if (keep) begin
        burst_cnt_nxt = burst_cnt + CW'(1);
      end else begin
        owner_nxt     = gnt_idx;
        burst_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid   <= 1'b0;
      pipe_id      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_opaque_q <= 1'b0;
    end else begin
      pipe_valid   <= any_gnt;
      pipe_id      <= gnt_idx;
      rsp_valid_q  <= pipe_valid;
      rsp_id_q     <= pipe_id;
      rsp_data_q   <= bus.rom_data;
      rsp_opaque_q <= (bus.rom_data != TRANSPARENT);
    end
  end

  assign bus.gnt        = gnt_oh;
  assign bus.rom_en     = any_gnt;
  assign bus.rom_addr   = any_gnt ? bus.req_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_opaque = rsp_opaque_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: per-cycle grant vectors checked inline, responses
// scoreboarded against a queue filled at grant time and drained by an independent monitor.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [11:0] data;
    logic        opaque;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t q[$];
  logic [13:0] addr_tab [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sprite_rom_arbiter_if #(.NUM_REQ(4)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(4), .BURST(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [11:0] rom_word(input logic [13:0] a);
    case (a)
      14'h0005: return 12'h0F0;
      14'h0010: return 12'hF0F;
      default:  return a[11:0] ^ 12'h3C3;
    endcase
  endfunction

  // Sprite ROM: one-cycle registered read while enabled.
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; gnt/rom checks are taken mid-cycle on the falling edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic do_rst);
    exp_t e;
    logic [13:0] ea;
    @(posedge clk);
    #1;
    rst          = do_rst;
    bus.req      = r;
    bus.req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    if (do_rst) while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
    @(negedge clk);
    ea = (eg == 4'b0) ? 14'h0 : addr_tab[oh2idx(eg)];
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("rom_en", 32'(bus.rom_en), 32'(eg != 4'b0));
    chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
    if (eg != 4'b0) begin
      e.due    = cyc + 2;
      e.id     = oh2idx(eg);
      e.data   = rom_word(ea);
      e.opaque = (e.data != 12'hF0F);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected at cycle %0d: got id %0d data 0x%0h, expected none", cyc, bus.rsp_id, bus.rsp_data);
      end else begin
        e = q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_opaque", 32'(bus.rsp_opaque), 32'(e.opaque));
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      fails++;
      $display("FAIL rsp_missing at cycle %0d: got rsp_valid 0, expected id %0d due %0d", cyc, e.id, e.due);
    end
  end

  initial begin
    logic [3:0] one;
    one          = 4'b0001;
    addr_tab[0]  = 14'h0005;
    addr_tab[1]  = 14'h0100;
    addr_tab[2]  = 14'h0200;
    addr_tab[3]  = 14'h0300;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_rsp_opaque", 32'(bus.rsp_opaque), 32'd0);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_rom_en", 32'(bus.rom_en), 32'd0);

    // Single requester, ROM word 5 = 0x0F0.
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0001, 1'b0);
    idle(3);

    // All four requesting from a fresh reset: 16-grant bursts 0,1,2,3 then back to 0.
    step(4'b0000, 4'b0000, 1'b1);
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 16; k++) step(4'b1111, one << b, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b1111, 4'b0001, 1'b0);
    idle(3);

    // Owner 1 drops after 5 grants; 2 takes over with a fresh 16-grant budget, then 3.
    for (int k = 0; k < 5; k++) step(4'b1110, 4'b0010, 1'b0);
    for (int k = 0; k < 16; k++) step(4'b1100, 4'b0100, 1'b0);
    step(4'b1100, 4'b1000, 1'b0);
    idle(3);

    // Lone requester 3 across two burst expiries.
    for (int k = 0; k < 40; k++) step(4'b1000, 4'b1000, 1'b0);
    idle(3);

    // Transparent colour key fetched by requester 2.
    addr_tab[2] = 14'h0010;
    step(4'b0100, 4'b0100, 1'b0);
    idle(3);

    // Reset with a word in flight; after reset owner is 3 so 0110 grants requester 1.
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    step(4'b0110, 4'b0010, 1'b0);
    chk("rsp_valid_after_rst", 32'(bus.rsp_valid), 32'd0);
    idle(4);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port, 1-cycle-latency sprite ROM (12-bit RGB words, 14-bit address, read only when enable is high) between several sprite engines (Mario, enemies, coins, blocks) that fetch pixels during the VGA scan.
- Per cycle: round-robin grant with bounded burst ownership, drive of ROM enable/address, and return of each fetched word tagged with the requester ID and an opacity flag.
- Sits between the sprite engines and the sprite ROM instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 14, ROM address width.
- DATA_W, 12, ROM word width (4:4:4 RGB).
- BURST, 16, maximum consecutive grants to one requester while it keeps requesting.
- TRANSPARENT, 12'hF0F, colour key treated as transparent.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester fetch request, level.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rom_en  out  1  ROM enable, equals |gnt.
- rom_addr  out  ADDR_W  address of granted requester; 0 when no grant.
- rom_data  in  DATA_W  ROM output, valid the cycle after rom_en.
- rsp_valid  out  1  registered; response word valid.
- rsp_id  out  $clog2(NUM_REQ)  registered; requester the word belongs to.
- rsp_data  out  DATA_W  registered; fetched word.
- rsp_opaque  out  1  registered; rsp_data != TRANSPARENT.

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge clears all state.
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_opaque=0, owner=NUM_REQ-1, burst_cnt=0, pipe_valid=0, pipe_id=0.
- Fixed latency of 2 cycles:
  - Cycle T: gnt[i]=1, rom_en=1, rom_addr=req_addr[i].
  - Edge T→T+1: pipe_valid<=1, pipe_id<=i. The ROM registers its data.
  - Edge T+1→T+2: rsp_valid<=pipe_valid, rsp_id<=pipe_id, rsp_data<=rom_data, rsp_opaque<=(rom_data!=TRANSPARENT).
  - rsp_* are valid during T+2.
- Fully pipelined: one grant per cycle, back-to-back, no bubbles.
- Grant selection (combinational, each cycle):
  - Keep owner if req[owner]=1 and burst_cnt < BURST-1.
  - Otherwise pick the first i with req[i]=1, scanning owner+1, owner+2, … modulo NUM_REQ (wraps; includes owner last).
- Two-state FSM:
  - IDLE (no grant last cycle): req=0 → stay, gnt=0, rom_en=0, rom_addr=0, pipe_valid<=0, owner and burst_cnt unchanged.
  - IDLE → BURST on any grant.
  - BURST: grant to the same owner → burst_cnt<=burst_cnt+1. Grant to a different requester → owner<=new, burst_cnt<=0. No grant → IDLE, burst_cnt<=0.
- Burst expiry: on the grant that makes burst_cnt reach BURST-1, the next cycle rearbitrates from owner+1. If owner is the only requester, it is re-granted and burst_cnt restarts at 0 (no idle cycle).
- Owner drops req mid-burst: next requester gets the grant in the same cycle; the dropped owner's in-flight word still returns.
- Simultaneous req: exactly one gnt bit; gnt is never non-one-hot.
- Addresses of non-granted requesters are ignored; requesters must hold req_addr stable until granted.
- rst mid-operation: all in-flight words are discarded; rsp_valid=0 in the cycle after the rst edge and stays 0 until 2 cycles after the first post-reset grant.
- gnt, rom_en and rom_addr are forced to 0 while rst=1.

Decomposition:
- Shared package sprite_pkg: SPR_ADDR_W=14, SPR_DATA_W=12, SPR_TRANSPARENT=12'hF0F, requester ID constants (REQ_MARIO=0, REQ_ENEMY=1, REQ_COIN=2, REQ_BLOCK=3).
- One sub-module: rr_pick (combinational rotate-priority one-hot picker; inputs req and start index; outputs one-hot and index).

Test Plan:
- Single requester: req=4'b0001, req_addr[0]=0x0005, ROM word 5=0x0F0 for 3 cycles → gnt=0001 every cycle; rsp_valid=1, rsp_id=0, rsp_data=0x0F0, rsp_opaque=1 from cycle 2 for 3 cycles.
- All four requesting, BURST=16 → gnt to 0 for 16 cycles, then 1 for 16, then 2, 3, then 0 again; rsp_id follows the same sequence delayed by 2 cycles.
- Owner 1 drops req after 5 grants while 2 and 3 request → 6th cycle gnt=0100; burst_cnt restarts at 0.
- Lone requester 3 held for 40 cycles → uninterrupted gnt=1000 across burst expiry; rsp_valid=1 continuously from cycle 2.
- ROM word 0x0010 = 0xF0F fetched → rsp_data=0xF0F, rsp_opaque=0.
- rst pulsed one cycle while 2 words are in flight → rsp_valid=0 the next cycle; after rst, req=4'b0110 → first grant goes to requester 1.
